// File: rtl/time_setter_if.sv
// time_setter_if: groups the button, running-time, shadow-time and control
// signals between the time-setting controller and the rest of the clock.
//   master : button/time source (debouncer + counters); drives btn_*, cur_*
//   slave  : time_setter; drives set_*, load, sec_clr, hold, edit_field
interface time_setter_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_cancel;
  logic [3:0] cur_min0;
  logic [2:0] cur_min1;
  logic [3:0] cur_hr0;
  logic [1:0] cur_hr1;
  logic [3:0] set_min0;
  logic [2:0] set_min1;
  logic [3:0] set_hr0;
  logic [1:0] set_hr1;
  logic       load;
  logic       sec_clr;
  logic       hold;
  logic [1:0] edit_field;

  modport master (
    output btn_mode, btn_inc, btn_dec, btn_cancel,
    output cur_min0, cur_min1, cur_hr0, cur_hr1,
    input  set_min0, set_min1, set_hr0, set_hr1,
    input  load, sec_clr, hold, edit_field
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, btn_cancel,
    input  cur_min0, cur_min1, cur_hr0, cur_hr1,
    output set_min0, set_min1, set_hr0, set_hr1,
    output load, sec_clr, hold, edit_field
  );
endinterface

// File: rtl/time_setter.sv
// time_setter: time-setting controller for the 24-hour digital clock.
// Captures the running time into shadow BCD registers on btn_mode, lets the
// user edit hours then minutes with inc/dec, and commits with a one-cycle
// load/sec_clr strobe. hold stays high while editing to freeze the timebase.
// Ports:
//   clk  - system clock
//   clr  - synchronous active-high reset
//   bus  - time_setter_if.slave: buttons, cur_* in; set_*, load, sec_clr,
//          hold, edit_field out (all outputs registered)
module time_setter (
  input  logic          clk,
  input  logic          clr,
  time_setter_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EDIT_HR  = 2'd1,
    EDIT_MIN = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] hr1;
  logic [3:0] hr0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic       load_r;
  logic       sec_clr_r;
  logic       hold_r;
  logic [1:0] field_r;

  // BCD neighbours of the current shadow value
  logic [1:0] hr1_inc, hr1_dec;
  logic [3:0] hr0_inc, hr0_dec;
  logic [2:0] min1_inc, min1_dec;
  logic [3:0] min0_inc, min0_dec;

  logic step_up;
  logic step_dn;

  // Simultaneous inc and dec cancel out and leave the shadow unchanged.
  assign step_up = bus.btn_inc & ~bus.btn_dec;
  assign step_dn = bus.btn_dec & ~bus.btn_inc;

  always_comb begin
    hr1_inc = hr1;
    hr0_inc = hr0;
    if (hr1 == 2'd2 && hr0 == 4'd3) begin
      hr1_inc = 2'd0;
      hr0_inc = 4'd0;
    end else if (hr0 == 4'd9) begin
      hr1_inc = hr1 + 2'd1;
      hr0_inc = 4'd0;
    end else begin
      hr0_inc = hr0 + 4'd1;
    end

    hr1_dec = hr1;
    hr0_dec = hr0;
    if (hr1 == 2'd0 && hr0 == 4'd0) begin
      hr1_dec = 2'd2;
      hr0_dec = 4'd3;
    end else if (hr0 == 4'd0) begin
      hr1_dec = hr1 - 2'd1;
      hr0_dec = 4'd9;
    end else begin
      hr0_dec = hr0 - 4'd1;
    end

    // Minute wrap stays inside the minute field; hours are never touched.
    min1_inc = min1;
    min0_inc = min0;
    if (min0 == 4'd9) begin
      min0_inc = 4'd0;
      min1_inc = (min1 == 3'd5) ? 3'd0 : min1 + 3'd1;
    end else begin
      min0_inc = min0 + 4'd1;
    end

    min1_dec = min1;
    min0_dec = min0;
    if (min0 == 4'd0) begin
      min0_dec = 4'd9;
      min1_dec = (min1 == 3'd0) ? 3'd5 : min1 - 3'd1;
    end else begin
      min0_dec = min0 - 4'd1;
    end
  end

  // Outputs are registered alongside the state transition so they are
  // valid in the same cycle the new state takes effect.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= RUN;
      hr1       <= '0;
      hr0       <= '0;
      min1      <= '0;
      min0      <= '0;
      load_r    <= 1'b0;
      sec_clr_r <= 1'b0;
      hold_r    <= 1'b0;
      field_r   <= 2'b00;
    end else begin
      load_r    <= 1'b0;
      sec_clr_r <= 1'b0;
      case (state)
        RUN: begin
          if (bus.btn_mode) begin
            state   <= EDIT_HR;
            hr1     <= bus.cur_hr1;
            hr0     <= bus.cur_hr0;
            min1    <= bus.cur_min1;
            min0    <= bus.cur_min0;
            hold_r  <= 1'b1;
            field_r <= 2'b01;
          end
        end
        EDIT_HR: begin
          if (bus.btn_cancel) begin
            state   <= RUN;
            hold_r  <= 1'b0;
            field_r <= 2'b00;
          end else if (bus.btn_mode) begin
            state   <= EDIT_MIN;
            field_r <= 2'b10;
          end else if (step_up) begin
            hr1 <= hr1_inc;
            hr0 <= hr0_inc;
          end else if (step_dn) begin
            hr1 <= hr1_dec;
            hr0 <= hr0_dec;
          end
        end
        EDIT_MIN: begin
          if (bus.btn_cancel) begin
            state   <= RUN;
            hold_r  <= 1'b0;
            field_r <= 2'b00;
          end else if (bus.btn_mode) begin
            state     <= COMMIT;
            load_r    <= 1'b1;
            sec_clr_r <= 1'b1;
            field_r   <= 2'b00;
          end else if (step_up) begin
            min1 <= min1_inc;
            min0 <= min0_inc;
          end else if (step_dn) begin
            min1 <= min1_dec;
            min0 <= min0_dec;
          end
        end
        COMMIT: begin
          state   <= RUN;
          hold_r  <= 1'b0;
          field_r <= 2'b00;
        end
        default: begin
          state   <= RUN;
          hold_r  <= 1'b0;
          field_r <= 2'b00;
        end
      endcase
    end
  end

  assign bus.set_hr1    = hr1;
  assign bus.set_hr0    = hr0;
  assign bus.set_min1   = min1;
  assign bus.set_min0   = min0;
  assign bus.load       = load_r;
  assign bus.sec_clr    = sec_clr_r;
  assign bus.hold       = hold_r;
  assign bus.edit_field = field_r;

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed, table-driven bench for time_setter.
module tb_time_setter;

  logic clk;
  logic clr;

  time_setter_if bus ();

  time_setter dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // button word {clr, mode, inc, dec, cancel}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] CLR  = 5'b10000;
  localparam logic [4:0] MODE = 5'b01000;
  localparam logic [4:0] INC  = 5'b00100;
  localparam logic [4:0] DEC  = 5'b00010;
  localparam logic [4:0] CAN  = 5'b00001;

  // control word {load, sec_clr, hold, edit_field[1:0]}
  localparam logic [4:0] C_RUN = 5'b00000;
  localparam logic [4:0] C_HR  = 5'b00101;
  localparam logic [4:0] C_MN  = 5'b00110;
  localparam logic [4:0] C_CM  = 5'b11100;

  typedef struct {
    string      name;
    logic [4:0] btn;
    logic [12:0] cur;   // {hr1, hr0, min1, min0}
    logic [12:0] eset;
    logic [4:0]  ectl;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic logic [12:0] t(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check(input string name, input logic [12:0] gset,
                       input logic [12:0] eset, input logic [4:0] gctl,
                       input logic [4:0] ectl);
    n_cmp++;
    if (gset !== eset) begin
      n_err++;
      $display("FAIL %s set: got %0d%0d:%0d%0d expected %0d%0d:%0d%0d", name,
               gset[12:11], gset[10:7], gset[6:4], gset[3:0],
               eset[12:11], eset[10:7], eset[6:4], eset[3:0]);
    end
    n_cmp++;
    if (gctl !== ectl) begin
      n_err++;
      $display("FAIL %s ctl{load,sec_clr,hold,field}: got %b expected %b",
               name, gctl, ectl);
    end
  endtask

  task automatic step(input string name, input logic [4:0] btn,
                      input logic [12:0] cur, input logic [12:0] eset,
                      input logic [4:0] ectl);
    @(negedge clk);
    clr            = btn[4];
    bus.btn_mode   = btn[3];
    bus.btn_inc    = btn[2];
    bus.btn_dec    = btn[1];
    bus.btn_cancel = btn[0];
    {bus.cur_hr1, bus.cur_hr0, bus.cur_min1, bus.cur_min0} = cur;
    @(posedge clk);
    #1;
    check(name,
          {bus.set_hr1, bus.set_hr0, bus.set_min1, bus.set_min0}, eset,
          {bus.load, bus.sec_clr, bus.hold, bus.edit_field}, ectl);
  endtask

  vec_t vecs[25];

  initial begin
    clr            = 1'b1;
    bus.btn_mode   = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.btn_dec    = 1'b0;
    bus.btn_cancel = 1'b0;
    bus.cur_hr1    = '0;
    bus.cur_hr0    = '0;
    bus.cur_min1   = '0;
    bus.cur_min0   = '0;

    vecs[0]  = '{"reset_all_btn", CLR | MODE | INC | DEC | CAN, t(13, 47), t(0, 0),   C_RUN};
    vecs[1]  = '{"enter_1347",    MODE,      t(13, 47), t(13, 47), C_HR};
    vecs[2]  = '{"cancel_hr",     CAN,       t(13, 47), t(13, 47), C_RUN};
    vecs[3]  = '{"enter_2359",    MODE,      t(23, 59), t(23, 59), C_HR};
    vecs[4]  = '{"hr_inc_23_00",  INC,       t(23, 59), t(0, 59),  C_HR};
    vecs[5]  = '{"hr_dec_00_23",  DEC,       t(23, 59), t(23, 59), C_HR};
    vecs[6]  = '{"mode_over_inc", MODE | INC, t(23, 59), t(23, 59), C_MN};
    vecs[7]  = '{"min_inc_59_00", INC,       t(23, 59), t(23, 0),  C_MN};
    vecs[8]  = '{"min_dec_00_59", DEC,       t(23, 59), t(23, 59), C_MN};
    vecs[9]  = '{"min_inc_dec",   INC | DEC, t(23, 59), t(23, 59), C_MN};
    vecs[10] = '{"cancel_mode",   CAN | MODE, t(23, 59), t(23, 59), C_RUN};
    vecs[11] = '{"idle_no_load",  NONE,      t(12, 34), t(23, 59), C_RUN};
    vecs[12] = '{"enter_1010",    MODE,      t(10, 10), t(10, 10), C_HR};
    vecs[13] = '{"hr_dec_10_09",  DEC,       t(10, 10), t(9, 10),  C_HR};
    vecs[14] = '{"hr_inc_09_10",  INC,       t(10, 10), t(10, 10), C_HR};
    vecs[15] = '{"to_min",        MODE,      t(10, 10), t(10, 10), C_MN};
    vecs[16] = '{"min_dec_10_09", DEC,       t(10, 10), t(10, 9),  C_MN};
    vecs[17] = '{"min_inc_09_10", INC,       t(10, 10), t(10, 10), C_MN};
    vecs[18] = '{"clr_mid_edit",  CLR | MODE, t(10, 10), t(0, 0),  C_RUN};
    vecs[19] = '{"enter_1900",    MODE,      t(19, 0),  t(19, 0),  C_HR};
    vecs[20] = '{"hr_inc_19_20",  INC,       t(19, 0),  t(20, 0),  C_HR};
    vecs[21] = '{"to_min_2000",   MODE,      t(19, 0),  t(20, 0),  C_MN};
    vecs[22] = '{"min_dec_wrap",  DEC,       t(19, 0),  t(20, 59), C_MN};
    vecs[23] = '{"cancel_min",    CAN,       t(19, 0),  t(20, 59), C_RUN};
    vecs[24] = '{"run_ignores",   INC | DEC | CAN, t(5, 5), t(20, 59), C_RUN};

    for (int i = 0; i < 25; i++)
      step(vecs[i].name, vecs[i].btn, vecs[i].cur, vecs[i].eset, vecs[i].ectl);

    // Full commit: shadow must not follow cur_* once captured.
    step("c_enter_0830", MODE, t(8, 30), t(8, 30),  C_HR);
    step("c_inc1",       INC,  t(8, 31), t(9, 30),  C_HR);
    step("c_inc2",       INC,  t(8, 31), t(10, 30), C_HR);
    step("c_to_min",     MODE, t(8, 31), t(10, 30), C_MN);
    step("c_dec",        DEC,  t(8, 31), t(10, 29), C_MN);
    step("c_commit",     MODE, t(8, 31), t(10, 29), C_CM);
    step("c_mode_in_cm", MODE, t(8, 31), t(10, 29), C_RUN);
    step("c_after",      NONE, t(8, 31), t(10, 29), C_RUN);
    // Back-to-back pulses each take effect.
    step("b_enter",      MODE, t(22, 58), t(22, 58), C_HR);
    step("b_inc1",       INC,  t(22, 58), t(23, 58), C_HR);
    step("b_inc2",       INC,  t(22, 58), t(0, 58),  C_HR);
    step("b_cancel",     CAN,  t(22, 58), t(0, 58),  C_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
